// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter
//   Two-master / eight-slave bus arbiter with address decode and timeout.
//   Master 0 is instruction fetch, master 1 is load/store. Only one
//   transaction is in flight at a time. Requests are granted round-robin
//   from IDLE, decoded against the SoC memory map, and forwarded to one
//   slave. Unmapped addresses and stalled slaves return an error response.
//
// Parameters
//   TIMEOUT   cycles allowed from entering ADDR to slave rvalid (0 = off)
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   m_req/m_addr/m_we/m_be/m_wdata   per-master request and fields
//   m_gnt                combinational accept, at most one hot
//   m_rvalid             registered one-cycle response pulse per master
//   m_rdata, m_err       shared response data / error flag
//   s_req                one-hot slave request (asserted in ADDR only)
//   s_addr/s_we/s_be/s_wdata   latched fields shared by all slaves
//   s_gnt, s_rvalid, s_rdata   per-slave accept, response valid, read data
module soc_bus_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      m_req,
  input  logic [1:0][31:0] m_addr,
  input  logic [1:0]      m_we,
  input  logic [1:0][3:0] m_be,
  input  logic [1:0][31:0] m_wdata,
  output logic [1:0]      m_gnt,
  output logic [1:0]      m_rvalid,
  output logic [31:0]     m_rdata,
  output logic            m_err,
  output logic [7:0]      s_req,
  output logic [31:0]     s_addr,
  output logic            s_we,
  output logic [3:0]      s_be,
  output logic [31:0]     s_wdata,
  input  logic [7:0]      s_gnt,
  input  logic [7:0]      s_rvalid,
  input  logic [7:0][31:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP, ERR} state_t;

  // Counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          sel_owner;
  logic [31:0]   sel_addr;
  logic          dec_hit;
  logic [2:0]    dec_idx;
  logic [1:0]    gnt_raw;
  logic          timeout_hit;

  // Round-robin: on a tie the master that did not win last time goes next.
  assign sel_owner = (m_req == 2'b11) ? ~last_owner_q : m_req[1];
  assign sel_addr  = m_addr[sel_owner];

  // Memory map decode of the candidate address.
  always_comb begin
    dec_hit = 1'b1;
    dec_idx = 3'd0;
    if (sel_addr[31:12] == 20'h00000)      dec_idx = 3'd0;  // boot ROM, 4 KiB
    else if (sel_addr[31:14] == 18'h00004) dec_idx = 3'd1;  // code RAM, 16 KiB @ 0x0001_0000
    else if (sel_addr[31:14] == 18'h00040) dec_idx = 3'd2;  // data RAM, 16 KiB @ 0x0010_0000
    else if (sel_addr[31:12] == 20'h01000) dec_idx = 3'd3;  // GPIO
    else if (sel_addr[31:12] == 20'h01001) dec_idx = 3'd4;  // SPI
    else if (sel_addr[31:12] == 20'h01002) dec_idx = 3'd5;  // UART
    else if (sel_addr[31:12] == 20'h01003) dec_idx = 3'd6;  // timer
    else if (sel_addr[31:16] == 16'h0101)  dec_idx = 3'd7;  // PMC, 64 KiB
    else                                   dec_hit = 1'b0;
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rvalid_d     = 2'b00;
    rdata_d      = 32'd0;
    err_d        = 1'b0;
    gnt_raw      = 2'b00;

    case (state_q)
      IDLE: begin
        if (|m_req) begin
          gnt_raw[sel_owner] = 1'b1;
          owner_d      = sel_owner;
          last_owner_d = sel_owner;
          idx_d        = dec_idx;
          addr_d       = sel_addr;
          we_d         = m_we[sel_owner];
          be_d         = m_be[sel_owner];
          wdata_d      = m_wdata[sel_owner];
          cnt_d        = '0;
          if (dec_hit) begin
            state_d = ADDR;
          end else begin
            // The error pulse is registered on the way into ERR so the
            // master sees it one cycle after its grant.
            state_d             = ERR;
            rvalid_d[sel_owner] = 1'b1;
            err_d               = 1'b1;
          end
        end
      end

      ADDR: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout_hit) begin
          state_d           = IDLE;
          rvalid_d[owner_q] = 1'b1;
          err_d             = 1'b1;
        end else if (s_gnt[idx_q]) begin
          state_d = RESP;
        end
      end

      RESP: begin
        cnt_d = cnt_q + CW'(1);
        // A response arriving on the last allowed cycle still completes.
        if (s_rvalid[idx_q]) begin
          state_d           = IDLE;
          rvalid_d[owner_q] = 1'b1;
          rdata_d           = we_q ? 32'd0 : s_rdata[idx_q];
        end else if (timeout_hit) begin
          state_d           = IDLE;
          rvalid_d[owner_q] = 1'b1;
          err_d             = 1'b1;
        end
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      idx_q        <= 3'd0;
      addr_q       <= 32'd0;
      we_q         <= 1'b0;
      be_q         <= 4'd0;
      wdata_q      <= 32'd0;
      cnt_q        <= '0;
      rvalid_q     <= 2'b00;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Grant is combinational, so it must be masked while reset is held.
  assign m_gnt    = rst ? 2'b00 : gnt_raw;
  assign m_rvalid = rvalid_q;
  assign m_rdata  = rdata_q;
  assign m_err    = err_q;

  assign s_addr   = addr_q;
  assign s_we     = we_q;
  assign s_be     = be_q;
  assign s_wdata  = wdata_q;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sreq
      assign s_req[gi] = (state_q == ADDR) && (idx_q == 3'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Self-checking bench for soc_bus_arbiter (TIMEOUT = 16).
// Directed steps followed by randomized transactions; expectations come
// from a memory-map range table, a round-robin owner variable and a
// latency model expressed in cycles after entering ADDR.
module tb_soc_bus_arbiter;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       m_req = '0;
  logic [1:0][31:0] m_addr = '0;
  logic [1:0]       m_we = '0;
  logic [1:0][3:0]  m_be = '0;
  logic [1:0][31:0] m_wdata = '0;
  logic [1:0]       m_gnt;
  logic [1:0]       m_rvalid;
  logic [31:0]      m_rdata;
  logic             m_err;
  logic [7:0]       s_req;
  logic [31:0]      s_addr;
  logic             s_we;
  logic [3:0]       s_be;
  logic [31:0]      s_wdata;
  logic [7:0]       s_gnt = '0;
  logic [7:0]       s_rvalid = '0;
  logic [7:0][31:0] s_rdata = '0;

  int n_total = 0;
  int n_pass  = 0;
  int model_last = 1;  // last winner of arbitration, as after reset

  logic [31:0] map_base [8] = '{32'h0000_0000, 32'h0001_0000, 32'h0010_0000, 32'h0100_0000,
                                32'h0100_1000, 32'h0100_2000, 32'h0100_3000, 32'h0101_0000};
  logic [31:0] map_size [8] = '{32'h1000, 32'h4000, 32'h4000, 32'h1000,
                                32'h1000, 32'h1000, 32'h1000, 32'h1_0000};
  logic [31:0] bnd [13] = '{32'h0000_0FFC, 32'h0000_1000, 32'h0000_FFFC, 32'h0001_3FFC,
                            32'h0001_4000, 32'h0010_3FFC, 32'h0010_4000, 32'h0100_0000,
                            32'h0100_3FFC, 32'h0100_4000, 32'h00FF_FFFC, 32'h0101_FFFC,
                            32'h0102_0000};

  soc_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic void ref_decode(input logic [31:0] a, output bit hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < 8; i++)
      if (a >= map_base[i] && a < map_base[i] + map_size[i]) begin
        hit = 1'b1;
        idx = i;
      end
  endfunction

  task automatic rand_fields(input int m);
    int s;
    s = $urandom_range(0, 8);
    if (s == 8) m_addr[m] = $urandom;
    else m_addr[m] = (map_base[s] + ($urandom % map_size[s])) & 32'hFFFF_FFFC;
    m_we[m]    = 1'($urandom);
    m_be[m]    = 4'($urandom);
    m_wdata[m] = $urandom;
  endtask

  // One complete transaction. Caller has set the fields of every master in
  // req; the slave accepts after g_wait cycles in ADDR and responds r_wait
  // cycles after entering RESP, or never when hang is set.
  task automatic txn(input logic [1:0] req, input int g_wait, input int r_wait,
                     input bit hang, input logic [31:0] data);
    int own, idx, t_done, resp_k;
    bit hit, tmo;
    logic [31:0] ea, ewd, exp_rd;
    logic ewe;
    logic [3:0] ebe;
    logic [7:0] oh;
    own = (req == 2'b11) ? 1 - model_last : (req[1] ? 1 : 0);
    model_last = own;
    ea = m_addr[own]; ewd = m_wdata[own]; ewe = m_we[own]; ebe = m_be[own];
    ref_decode(ea, hit, idx);
    m_req = req;
    #1;
    chk("gnt", 32'(m_gnt), 32'(1 << own));
    cyc();
    // Winner is free to drop req and change its fields after the grant.
    m_req[own] = 1'b0;
    m_addr[own] = $urandom; m_wdata[own] = $urandom; m_we[own] = ~ewe; m_be[own] = ~ebe;
    if (!hit) begin
      chk("err_rvalid", 32'(m_rvalid), 32'(1 << own));
      chk("err_flag", 32'(m_err), 32'd1);
      chk("err_rdata", m_rdata, 32'd0);
      chk("err_sreq", 32'(s_req), 32'd0);
      chk("err_gnt", 32'(m_gnt), 32'd0);
      cyc();
      $display("txn m%0d addr=%08h we=%0d unmapped err=1", own, ea, ewe);
      return;
    end
    oh = 8'(1 << idx);
    chk("s_addr", s_addr, ea);
    chk("s_we", 32'(s_we), 32'(ewe));
    chk("s_be", 32'(s_be), 32'(ebe));
    chk("s_wdata", s_wdata, ewd);
    t_done = g_wait + 1 + r_wait;  // cycle (from ADDR entry) of slave rvalid
    tmo    = hang || (t_done > TMO - 1);
    resp_k = tmo ? TMO : t_done + 1;
    exp_rd = (tmo || ewe) ? 32'd0 : data;
    for (int k = 0; k < resp_k; k++) begin
      chk("s_req", 32'(s_req), (k <= g_wait) ? 32'(oh) : 32'd0);
      chk("s_addr_hold", s_addr, ea);
      chk("busy_rvalid", 32'(m_rvalid), 32'd0);
      chk("busy_gnt", 32'(m_gnt), 32'd0);
      s_gnt    = 8'($urandom) & ~oh;
      s_rvalid = 8'($urandom) & ~oh;
      for (int s = 0; s < 8; s++) s_rdata[s] = $urandom;
      if (k == g_wait) s_gnt = s_gnt | oh;
      if (!hang && k == t_done) begin
        s_rvalid = s_rvalid | oh;
        s_rdata[idx] = data;
      end
      cyc();
    end
    s_gnt = '0;
    s_rvalid = '0;
    chk("rvalid", 32'(m_rvalid), 32'(1 << own));
    chk("m_err", 32'(m_err), 32'(tmo));
    chk("m_rdata", m_rdata, exp_rd);
    $display("txn m%0d addr=%08h we=%0d slave=%0d gw=%0d rw=%0d err=%0d rdata=%08h",
             own, ea, ewe, idx, g_wait, r_wait, tmo, exp_rd);
  endtask

  initial begin
    #1 rst = 1'b1;
    m_req = 2'b11;
    #1;
    chk("rst_gnt", 32'(m_gnt), 32'd0);
    chk("rst_sreq", 32'(s_req), 32'd0);
    chk("rst_rvalid", 32'(m_rvalid), 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_saddr", s_addr, 32'd0);
    chk("rst_swe", 32'(s_we), 32'd0);
    chk("rst_sbe", 32'(s_be), 32'd0);
    chk("rst_swdata", s_wdata, 32'd0);
    m_req = 2'b00;
    cyc();
    #3 rst = 1'b0;
    cyc();

    // Single zero-wait read, master 0 -> code RAM.
    m_addr[0] = 32'h0001_0040; m_we[0] = 1'b0; m_be[0] = 4'hF;
    txn(2'b01, 0, 0, 1'b0, 32'hDEAD_BEEF);

    // Write from master 1 to UART.
    m_addr[1] = 32'h0100_2004; m_we[1] = 1'b1; m_be[1] = 4'b0001; m_wdata[1] = 32'h1234_5678;
    txn(2'b10, 0, 0, 1'b0, 32'hFFFF_0000);

    // Repeated ties to data RAM; the loser keeps its request pending.
    for (int n = 0; n < 4; n++) begin
      for (int m = 0; m < 2; m++)
        if (!m_req[m]) begin
          m_addr[m] = 32'h0010_0000 + 32'(n * 16 + m * 4);
          m_we[m] = 1'b0; m_be[m] = 4'hF; m_wdata[m] = 32'd0;
        end
      txn(2'b11, 0, 0, 1'b0, $urandom);
    end
    if (m_req != 2'b00) txn(m_req, 0, 0, 1'b0, $urandom);

    // Unmapped read.
    m_addr[0] = 32'h0000_1000; m_we[0] = 1'b0;
    txn(2'b01, 0, 0, 1'b0, 32'h0);

    // Timer slave never answers; a late rvalid afterwards is ignored.
    m_addr[0] = 32'h0100_3000; m_we[0] = 1'b0;
    txn(2'b01, 0, 0, 1'b1, 32'h0);
    s_rvalid = 8'h40; s_rdata[6] = 32'h5555_AAAA;
    cyc();
    s_rvalid = '0;
    chk("late_rvalid", 32'(m_rvalid), 32'd0);

    // Response on the last allowed cycle completes; one cycle later times out.
    m_addr[0] = 32'h0010_0100; m_we[0] = 1'b0;
    txn(2'b01, 3, 11, 1'b0, 32'hA5A5_0F0F);
    m_addr[1] = 32'h0010_0104; m_we[1] = 1'b0;
    txn(2'b10, 3, 12, 1'b0, 32'hA5A5_0F0F);

    // Memory-map edges.
    for (int i = 0; i < 13; i++) begin
      m_addr[0] = bnd[i]; m_we[0] = 1'b0;
      txn(2'b01, 0, 0, 1'b0, $urandom);
    end

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] req;
      for (int m = 0; m < 2; m++) if (!m_req[m]) rand_fields(m);
      req = 2'($urandom_range(1, 3)) | m_req;
      txn(req, $urandom_range(0, 3), $urandom_range(0, 3) + ((n % 8 == 7) ? 12 : 0),
          1'b0, $urandom);
    end
    if (m_req != 2'b00) txn(m_req, 0, 0, 1'b0, $urandom);

    // Reset while in ADDR: s_req drops without a clock edge.
    m_addr[0] = 32'h0010_0010; m_we[0] = 1'b0;
    m_req = 2'b01;
    #1 chk("rsta_gnt", 32'(m_gnt), 32'd1);
    cyc();
    m_req = 2'b00;
    chk("rsta_sreq_pre", 32'(s_req), 32'h04);
    #2 rst = 1'b1;
    #1 chk("rsta_sreq", 32'(s_req), 32'd0);
    cyc();
    #3 rst = 1'b0;
    model_last = 1;
    cyc();

    // Reset during RESP with the slave answering: no response is issued.
    m_addr[0] = 32'h0010_0020; m_we[0] = 1'b0;
    m_req = 2'b01;
    #1 chk("rstb_gnt", 32'(m_gnt), 32'd1);
    cyc();
    m_addr[1] = 32'h0010_0024; m_we[1] = 1'b0;
    m_req = 2'b10;
    s_gnt = 8'h04;
    cyc();
    s_gnt = '0;
    chk("rstb_sreq_resp", 32'(s_req), 32'd0);
    s_rvalid = 8'h04; s_rdata[2] = 32'hCAFE_0001;
    #2 rst = 1'b1;
    m_req = 2'b11;
    #1;
    chk("rstb_gnt_rst", 32'(m_gnt), 32'd0);
    chk("rstb_sreq", 32'(s_req), 32'd0);
    chk("rstb_rvalid", 32'(m_rvalid), 32'd0);
    cyc();
    chk("rstb_noresp", 32'(m_rvalid), 32'd0);
    chk("rstb_gnt_hold", 32'(m_gnt), 32'd0);
    s_rvalid = '0;
    #3 rst = 1'b0;
    model_last = 1;
    txn(2'b11, 0, 0, 1'b0, $urandom);  // master 0 must win after reset
    if (m_req != 2'b00) txn(m_req, 0, 0, 1'b0, $urandom);

    // Reset during an rvalid pulse clears it immediately.
    m_addr[0] = 32'h0000_0200; m_we[0] = 1'b0;
    txn(2'b01, 0, 0, 1'b0, 32'h0BAD_F00D);
    #2 rst = 1'b1;
    #1;
    chk("rstc_rvalid", 32'(m_rvalid), 32'd0);
    chk("rstc_rdata", m_rdata, 32'd0);
    cyc();
    #3 rst = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
